// File: rtl/box_frame_latch.sv
// Converts centre/size detections into clamped corner boxes, keeps the best box of each
// frame and latches it onto frame-stable outputs one cycle after every vsync rising edge.
module box_frame_latch #(
   parameter int         H_ACTIVE    = 1280,
   parameter int         V_ACTIVE    = 720,
   parameter logic [7:0] SCORE_TH    = 8'd128,
   parameter int         HOLD_FRAMES = 2
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        vga_vsync_i,
   input  logic        det_valid,
   output logic        det_ready,
   input  logic [10:0] det_cx,
   input  logic [9:0]  det_cy,
   input  logic [10:0] det_w,
   input  logic [9:0]  det_h,
   input  logic [7:0]  det_score,
   output logic [31:0] box_x1,
   output logic [31:0] box_y1,
   output logic [31:0] box_x2,
   output logic [31:0] box_y2,
   output logic        box_valid
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_CMP} state_t;

   localparam logic signed [12:0] X_MAX = 13'(H_ACTIVE - 1);
   localparam logic signed [12:0] Y_MAX = 13'(V_ACTIVE - 1);
   localparam logic [3:0]         HOLD_MAX = 4'(HOLD_FRAMES);

   state_t state_q, state_d;
   logic [10:0] cx_q, cx_d, w_q, w_d;
   logic [9:0]  cy_q, cy_d, h_q, h_d;
   logic [7:0]  score_q, score_d;
   logic signed [12:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
   logic               cand_valid_q, cand_valid_d;
   logic signed [12:0] cand_x1_q, cand_x1_d, cand_y1_q, cand_y1_d;
   logic signed [12:0] cand_x2_q, cand_x2_d, cand_y2_q, cand_y2_d;
   logic [7:0]         cand_score_q, cand_score_d;
   logic [12:0] box_x1_q, box_x1_d, box_y1_q, box_y1_d;
   logic [12:0] box_x2_q, box_x2_d, box_y2_q, box_y2_d;
   logic        box_valid_q, box_valid_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic        vsync_d_q;

   logic signed [12:0] cx_ext, cy_ext, w_ext, h_ext;
   logic signed [12:0] x1_raw, y1_raw, x2_raw, y2_raw;
   logic               vs_edge, box_ok, better;

   assign vs_edge = vga_vsync_i & ~vsync_d_q;

   always_comb begin
      cx_ext = $signed({2'b00, cx_q});
      cy_ext = $signed({3'b000, cy_q});
      w_ext  = $signed({2'b00, w_q});
      h_ext  = $signed({3'b000, h_q});
      x1_raw = cx_ext - (w_ext >>> 1);
      x2_raw = cx_ext + (w_ext >>> 1);
      y1_raw = cy_ext - (h_ext >>> 1);
      y2_raw = cy_ext + (h_ext >>> 1);
   end

   // A box that collapses to zero area after clamping is dropped like a low-score one.
   assign box_ok = (state_q == S_CMP) && (x2_q > x1_q) && (y2_q > y1_q) && (score_q >= SCORE_TH);
   assign better = !cand_valid_q || (score_q > cand_score_q);

   always_comb begin
      state_d = state_q;
      cx_d = cx_q; cy_d = cy_q; w_d = w_q; h_d = h_q; score_d = score_q;
      x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
      case (state_q)
         S_IDLE: begin
            if (det_valid) begin
               cx_d = det_cx; cy_d = det_cy; w_d = det_w; h_d = det_h; score_d = det_score;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            x1_d = (x1_raw < 13'sd0) ? 13'sd0 : x1_raw;
            y1_d = (y1_raw < 13'sd0) ? 13'sd0 : y1_raw;
            x2_d = (x2_raw > X_MAX) ? X_MAX : x2_raw;
            y2_d = (y2_raw > Y_MAX) ? Y_MAX : y2_raw;
            state_d = S_CMP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cand_valid_d = cand_valid_q;
      cand_x1_d = cand_x1_q; cand_y1_d = cand_y1_q;
      cand_x2_d = cand_x2_q; cand_y2_d = cand_y2_q;
      cand_score_d = cand_score_q;
      box_x1_d = box_x1_q; box_y1_d = box_y1_q; box_x2_d = box_x2_q; box_y2_d = box_y2_q;
      box_valid_d = box_valid_q;
      hold_cnt_d = hold_cnt_q;
      // The commit reads the pre-update candidate; a box finishing in the same cycle opens the new frame.
      if (vs_edge) begin
         cand_valid_d = 1'b0;
         if (cand_valid_q) begin
            box_x1_d = cand_x1_q; box_y1_d = cand_y1_q;
            box_x2_d = cand_x2_q; box_y2_d = cand_y2_q;
            box_valid_d = 1'b1;
            hold_cnt_d = 4'd0;
         end else if (hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
         end else begin
            box_x1_d = '0; box_y1_d = '0; box_x2_d = '0; box_y2_d = '0;
            box_valid_d = 1'b0;
         end
      end
      if (box_ok && (vs_edge || better)) begin
         cand_valid_d = 1'b1;
         cand_x1_d = x1_q; cand_y1_d = y1_q; cand_x2_d = x2_q; cand_y2_d = y2_q;
         cand_score_d = score_q;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q <= S_IDLE;
         cx_q <= '0; cy_q <= '0; w_q <= '0; h_q <= '0; score_q <= '0;
         x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
         cand_valid_q <= 1'b0;
         cand_x1_q <= '0; cand_y1_q <= '0; cand_x2_q <= '0; cand_y2_q <= '0;
         cand_score_q <= '0;
         box_x1_q <= '0; box_y1_q <= '0; box_x2_q <= '0; box_y2_q <= '0;
         box_valid_q <= 1'b0;
         hold_cnt_q <= '0;
         vsync_d_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cx_q <= cx_d; cy_q <= cy_d; w_q <= w_d; h_q <= h_d; score_q <= score_d;
         x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
         cand_valid_q <= cand_valid_d;
         cand_x1_q <= cand_x1_d; cand_y1_q <= cand_y1_d;
         cand_x2_q <= cand_x2_d; cand_y2_q <= cand_y2_d;
         cand_score_q <= cand_score_d;
         box_x1_q <= box_x1_d; box_y1_q <= box_y1_d; box_x2_q <= box_x2_d; box_y2_q <= box_y2_d;
         box_valid_q <= box_valid_d;
         hold_cnt_q <= hold_cnt_d;
         vsync_d_q <= vga_vsync_i;
      end
   end

   // Gated with reset so every output reads 0 while reset is held.
   assign det_ready = (state_q == S_IDLE) && s_rst_n;
   assign box_x1    = {19'd0, box_x1_q};
   assign box_y1    = {19'd0, box_y1_q};
   assign box_x2    = {19'd0, box_x2_q};
   assign box_y2    = {19'd0, box_y2_q};
   assign box_valid = box_valid_q;

endmodule

// File: tb/tb_box_frame_latch.sv
// Directed bench for box_frame_latch: conversion, clamping, best-of-frame, hold/clear,
// vsync coincidence and mid-operation reset.
module tb_box_frame_latch;

   logic        sclk = 1'b0;
   logic        s_rst_n = 1'b0;
   logic        vga_vsync_i = 1'b0;
   logic        det_valid = 1'b0;
   logic        det_ready;
   logic [10:0] det_cx = '0;
   logic [9:0]  det_cy = '0;
   logic [10:0] det_w = '0;
   logic [9:0]  det_h = '0;
   logic [7:0]  det_score = '0;
   logic [31:0] box_x1, box_y1, box_x2, box_y2;
   logic        box_valid;

   int checks = 0;
   int errors = 0;

   box_frame_latch dut (
      .sclk(sclk), .s_rst_n(s_rst_n), .vga_vsync_i(vga_vsync_i),
      .det_valid(det_valid), .det_ready(det_ready),
      .det_cx(det_cx), .det_cy(det_cy), .det_w(det_w), .det_h(det_h), .det_score(det_score),
      .box_x1(box_x1), .box_y1(box_y1), .box_x2(box_x2), .box_y2(box_y2),
      .box_valid(box_valid)
   );

   always #5 sclk = ~sclk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_box(input string tag, input int x1, input int y1, input int x2,
                          input int y2, input logic v);
      chk({tag, "_x1"}, box_x1, 32'(x1));
      chk({tag, "_y1"}, box_y1, 32'(y1));
      chk({tag, "_x2"}, box_x2, 32'(x2));
      chk({tag, "_y2"}, box_y2, 32'(y2));
      chk({tag, "_valid"}, {31'd0, box_valid}, {31'd0, v});
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!det_ready && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, {31'd0, det_ready}, 32'd1);
   endtask

   task automatic drive(input logic [10:0] cx, input logic [9:0] cy, input logic [10:0] w,
                        input logic [9:0] h, input logic [7:0] s);
      det_cx = cx; det_cy = cy; det_w = w; det_h = h; det_score = s;
      det_valid = 1'b1;
      tick();
      det_valid = 1'b0;
      det_cx = 11'($urandom); det_cy = 10'($urandom);
      det_w = 11'($urandom); det_h = 10'($urandom); det_score = 8'($urandom);
   endtask

   task automatic send(input string tag, input logic [10:0] cx, input logic [9:0] cy,
                       input logic [10:0] w, input logic [9:0] h, input logic [7:0] s);
      wait_ready(tag);
      drive(cx, cy, w, h, s);
      tick();
      tick();
   endtask

   task automatic vsync();
      vga_vsync_i = 1'b1;
      tick();
      vga_vsync_i = 1'b0;
      tick();
   endtask

   // Second box reaches S_CMP exactly on the vsync edge cycle.
   task automatic coincide(input string tag, input logic [7:0] sd);
      send({tag, "_c"}, 11'd600, 10'd300, 11'd100, 10'd100, 8'd150);
      wait_ready({tag, "_d"});
      drive(11'd200, 10'd200, 11'd50, 10'd50, sd);
      chk({tag, "_busy"}, {31'd0, det_ready}, 32'd0);
      tick();
      vga_vsync_i = 1'b1;
      tick();
      chk_box({tag, "_old"}, 550, 250, 650, 350, 1'b1);
      vga_vsync_i = 1'b0;
      tick();
      vsync();
      chk_box({tag, "_new"}, 175, 175, 225, 225, 1'b1);
   endtask

   initial begin
      #2;
      chk_box("reset", 0, 0, 0, 0, 1'b0);
      chk("reset_ready", {31'd0, det_ready}, 32'd0);
      tick();
      s_rst_n = 1'b1;
      tick();

      // Centred box; outputs move only on the edge after vsync rises
      send("t1", 11'd640, 10'd360, 11'd100, 10'd50, 8'd200);
      vga_vsync_i = 1'b1;
      #1;
      chk("t1_pre_valid", {31'd0, box_valid}, 32'd0);
      tick();
      chk_box("t1", 590, 335, 690, 385, 1'b1);
      vga_vsync_i = 1'b0;
      tick();

      // Clamping at left and bottom
      send("t2", 11'd20, 10'd710, 11'd100, 10'd40, 8'd200);
      vsync();
      chk_box("t2", 0, 690, 70, 719, 1'b1);

      // Best of frame: low score dropped, tie keeps first, zero-width rejected
      send("t3a", 11'd100, 10'd100, 11'd40, 10'd40, 8'd100);
      send("t3b", 11'd300, 10'd200, 11'd40, 10'd20, 8'd220);
      send("t3c", 11'd800, 10'd400, 11'd60, 10'd30, 8'd220);
      send("t3d", 11'd500, 10'd300, 11'd1, 10'd20, 8'd255);
      vsync();
      chk_box("t3", 280, 190, 320, 210, 1'b1);

      // Hold for two empty frames, clear on the third
      vsync();
      chk_box("t4_v1", 280, 190, 320, 210, 1'b1);
      vsync();
      chk_box("t4_v2", 280, 190, 320, 210, 1'b1);
      vsync();
      chk_box("t4_v3", 0, 0, 0, 0, 1'b0);

      // Threshold boundary: 127 dropped, 128 accepted
      send("th127", 11'd200, 10'd100, 11'd20, 10'd10, 8'd127);
      vsync();
      chk_box("th127", 0, 0, 0, 0, 1'b0);
      send("th128", 11'd400, 10'd300, 11'd20, 10'd10, 8'd128);
      vsync();
      chk_box("th128", 390, 295, 410, 305, 1'b1);

      // Long vsync: one commit only, box arriving while high waits for next rise
      vga_vsync_i = 1'b1;
      tick();
      send("vh", 11'd1000, 10'd500, 11'd200, 10'd100, 8'd180);
      tick();
      tick();
      chk_box("vh_hold", 390, 295, 410, 305, 1'b1);
      vga_vsync_i = 1'b0;
      tick();
      vsync();
      chk_box("vh_next", 900, 450, 1100, 550, 1'b1);

      coincide("co_lo", 8'd140);
      coincide("co_hi", 8'd250);

      // Reset while a detection is in S_CALC
      wait_ready("rst");
      drive(11'd700, 10'd400, 11'd100, 10'd100, 8'd250);
      s_rst_n = 1'b0;
      #1;
      chk_box("rst_now", 0, 0, 0, 0, 1'b0);
      tick();
      s_rst_n = 1'b1;
      tick();
      chk("rst_ready", {31'd0, det_ready}, 32'd1);
      vsync();
      chk_box("rst_vs", 0, 0, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
